// File: rtl/vector_test_engine.sv
// vector_test_engine
// Vector-based DUT test engine. A loadable RAM holds {drive, expect, mask}
// entries; a run applies num_vectors entries to dut_dio for pass_count passes
// (0 = until abort), waits settle_cycles after each apply, samples dut_resp and
// compares it against expect under mask. Reports a saturating error count, the
// first failing address and a held pass/aborted verdict.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   vec_wr_en/addr/drive/expect/mask   vector RAM write port (ignored while busy)
//   start, abort                run control pulses
//   num_vectors, pass_count, settle_cycles   run configuration, sampled at start
//   dut_resp                    DUT response (already synchronised)
//   dut_dio                     drive outputs, hold last applied vector
//   busy, done                  run in progress / 1-cycle end-of-run pulse
//   pass, aborted               verdict of the last run (held)
//   error_count                 mismatching vectors, saturating
//   first_fail_addr/valid       address of first mismatch in the run
module vector_test_engine #(
   parameter  int DIO_W  = 32,
   parameter  int RESP_W = 32,
   parameter  int DEPTH  = 1024,
   parameter  int ERR_W  = 16,
   parameter  int LOOP_W = 8,
   parameter  int SET_W  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vec_wr_en,
   input  logic [ADDR_W-1:0] vec_wr_addr,
   input  logic [DIO_W-1:0]  vec_wr_drive,
   input  logic [RESP_W-1:0] vec_wr_expect,
   input  logic [RESP_W-1:0] vec_wr_mask,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   num_vectors,
   input  logic [LOOP_W-1:0] pass_count,
   input  logic [SET_W-1:0]  settle_cycles,
   input  logic [RESP_W-1:0] dut_resp,
   output logic [DIO_W-1:0]  dut_dio,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              aborted,
   output logic [ERR_W-1:0]  error_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic              first_fail_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_APPLY,
      S_SETTLE,
      S_SAMPLE,
      S_FINISH
   } state_t;

   localparam int              WORD_W  = DIO_W + 2 * RESP_W;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   state_t              state;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [WORD_W-1:0]   rd_word;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W:0]     nv_lat;
   logic [LOOP_W-1:0]   pc_lat;
   logic [LOOP_W-1:0]   pass_idx;
   logic [SET_W-1:0]    st_lat;
   logic [SET_W-1:0]    settle_cnt;
   logic [RESP_W-1:0]   exp_lat;
   logic [RESP_W-1:0]   mask_lat;
   logic                mismatch;
   logic                last_vec;
   logic                last_pass;

   assign mismatch  = |((dut_resp ^ exp_lat) & mask_lat);
   assign last_vec  = ({1'b0, addr} == nv_lat - 1'b1);
   assign last_pass = (pc_lat != '0) && ((pass_idx + 1'b1) == pc_lat);

   // Vector RAM: one write port, registered read of the current address.
   // A write in the start cycle lands before FETCH reads it.
   always_ff @(posedge clk) begin
      if (vec_wr_en && !busy)
         mem[vec_wr_addr] <= {vec_wr_drive, vec_wr_expect, vec_wr_mask};
      rd_word <= mem[addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         addr             <= '0;
         nv_lat           <= '0;
         pc_lat           <= '0;
         pass_idx         <= '0;
         st_lat           <= '0;
         settle_cnt       <= '0;
         exp_lat          <= '0;
         mask_lat         <= '0;
         dut_dio          <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         aborted          <= 1'b0;
         error_count      <= '0;
         first_fail_addr  <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         // Abort pre-empts every active state; a compare pending in SAMPLE is dropped.
         if (abort && (state inside {S_FETCH, S_APPLY, S_SETTLE, S_SAMPLE})) begin
            aborted <= 1'b1;
            state   <= S_FINISH;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     nv_lat           <= (num_vectors > DEPTH_V) ? DEPTH_V : num_vectors;
                     pc_lat           <= pass_count;
                     st_lat           <= settle_cycles;
                     error_count      <= '0;
                     first_fail_addr  <= '0;
                     first_fail_valid <= 1'b0;
                     pass             <= 1'b0;
                     aborted          <= 1'b0;
                     busy             <= 1'b1;
                     addr             <= '0;
                     pass_idx         <= '0;
                     state            <= (num_vectors == '0) ? S_FINISH : S_FETCH;
                  end
               end
               S_FETCH: state <= S_APPLY;
               S_APPLY: begin
                  dut_dio    <= rd_word[WORD_W-1 -: DIO_W];
                  exp_lat    <= rd_word[2*RESP_W-1 -: RESP_W];
                  mask_lat   <= rd_word[RESP_W-1:0];
                  settle_cnt <= st_lat;
                  state      <= (st_lat == '0) ? S_SAMPLE : S_SETTLE;
               end
               S_SETTLE: begin
                  settle_cnt <= settle_cnt - 1'b1;
                  if (settle_cnt == SET_W'(1))
                     state <= S_SAMPLE;
               end
               S_SAMPLE: begin
                  if (mismatch) begin
                     if (error_count != '1)
                        error_count <= error_count + 1'b1;
                     if (!first_fail_valid) begin
                        first_fail_addr  <= addr;
                        first_fail_valid <= 1'b1;
                     end
                  end
                  if (last_vec) begin
                     addr     <= '0;
                     pass_idx <= pass_idx + 1'b1;
                     state    <= last_pass ? S_FINISH : S_FETCH;
                  end else begin
                     addr  <= addr + 1'b1;
                     state <= S_FETCH;
                  end
               end
               S_FINISH: begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (error_count == '0) && !aborted;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vector_test_engine.sv
module tb_vector_test_engine;

   localparam int DIO_W  = 32;
   localparam int RESP_W = 32;
   localparam int DEPTH  = 16;
   localparam int ERR_W  = 4;
   localparam int LOOP_W = 8;
   localparam int SET_W  = 8;
   localparam int ADDR_W = 4;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic              clk;
   logic              rst_n;
   logic              vec_wr_en;
   logic [ADDR_W-1:0] vec_wr_addr;
   logic [DIO_W-1:0]  vec_wr_drive;
   logic [RESP_W-1:0] vec_wr_expect;
   logic [RESP_W-1:0] vec_wr_mask;
   logic              start;
   logic              abort;
   logic [ADDR_W:0]   num_vectors;
   logic [LOOP_W-1:0] pass_count;
   logic [SET_W-1:0]  settle_cycles;
   logic [RESP_W-1:0] dut_resp;
   logic [DIO_W-1:0]  dut_dio;
   logic              busy;
   logic              done;
   logic              pass;
   logic              aborted;
   logic [ERR_W-1:0]  error_count;
   logic [ADDR_W-1:0] first_fail_addr;
   logic              first_fail_valid;

   // DUT response: its own drive XOR a per-test key (key 0 = loopback)
   logic [31:0] key;
   assign dut_resp = dut_dio ^ key;

   vector_test_engine #(
      .DIO_W (DIO_W),
      .RESP_W(RESP_W),
      .DEPTH (DEPTH),
      .ERR_W (ERR_W),
      .LOOP_W(LOOP_W),
      .SET_W (SET_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .vec_wr_en       (vec_wr_en),
      .vec_wr_addr     (vec_wr_addr),
      .vec_wr_drive    (vec_wr_drive),
      .vec_wr_expect   (vec_wr_expect),
      .vec_wr_mask     (vec_wr_mask),
      .start           (start),
      .abort           (abort),
      .num_vectors     (num_vectors),
      .pass_count      (pass_count),
      .settle_cycles   (settle_cycles),
      .dut_resp        (dut_resp),
      .dut_dio         (dut_dio),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .aborted         (aborted),
      .error_count     (error_count),
      .first_fail_addr (first_fail_addr),
      .first_fail_valid(first_fail_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: what the bench believes is stored in the vector RAM
   logic [31:0] m_drive [DEPTH];
   logic [31:0] m_exp   [DEPTH];
   logic [31:0] m_mask  [DEPTH];

   // Observations of the latest run (cycle c = negedge after the c-th edge past the start edge)
   int          done_c;
   int          done_cnt;
   bit          busy_bad;
   logic [31:0] dio_log [$];

   function automatic bit mism(input int a);
      return ((m_drive[a] ^ key ^ m_exp[a]) & m_mask[a]) != 32'd0;
   endfunction

   function automatic int model_errs(input int nv, input int passes);
      int n = 0;
      for (int p = 0; p < passes; p++)
         for (int a = 0; a < nv; a++)
            if (mism(a)) n++;
      return (n > ERR_MAX) ? ERR_MAX : n;
   endfunction

   function automatic int model_ff(input int nv);
      for (int a = 0; a < nv; a++)
         if (mism(a)) return a;
      return -1;
   endfunction

   task automatic write_vec(input int a, input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
      vec_wr_en     = 1'b1;
      vec_wr_addr   = ADDR_W'(a);
      vec_wr_drive  = d;
      vec_wr_expect = e;
      vec_wr_mask   = m;
      @(negedge clk);
      vec_wr_en = 1'b0;
      m_drive[a] = d;
      m_exp[a]   = e;
      m_mask[a]  = m;
   endtask

   // Starts a run and records observations only; injections happen before edge c+1.
   task automatic do_run(input int nv, input int pc, input int st, input int max_c,
                         input int abort_at, input int restart_at, input int wr_at);
      num_vectors   = (ADDR_W + 1)'(nv);
      pass_count    = LOOP_W'(pc);
      settle_cycles = SET_W'(st);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dio_log.delete();
      done_c = -1;
      done_cnt = 0;
      busy_bad = 1'b0;
      for (int c = 0; c < max_c; c++) begin
         dio_log.push_back(dut_dio);
         if (done) begin
            done_cnt++;
            if (done_c < 0) done_c = c;
         end
         if (done_c < 0 && !busy) busy_bad = 1'b1;
         abort = (c == abort_at);
         start = (c == restart_at);
         if (c == restart_at) num_vectors = 1;
         vec_wr_en = (c == wr_at);
         if (c == wr_at) begin
            vec_wr_addr  = '0;
            vec_wr_drive = 32'hDEAD_BEEF;
         end
         if (done_c >= 0 && c >= done_c + 2) break;
         @(negedge clk);
      end
      abort = 1'b0;
      start = 1'b0;
      vec_wr_en = 1'b0;
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({dut_dio, busy, done, pass, aborted, error_count, first_fail_addr, first_fail_valid} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got dio=%h busy=%b done=%b pass=%b abt=%b err=%0d ffa=%0d ffv=%b required all zero",
                  dut_dio, busy, done, pass, aborted, error_count, first_fail_addr, first_fail_valid);
      end
   endtask

   task automatic test_single_pass;
      key = 0;
      for (int i = 0; i < 4; i++) write_vec(i, 32'(i + 1), 32'(i + 1), 32'hFFFF_FFFF);
      do_run(4, 1, 2, 60, -1, -1, -1);
      n_cmp++; if (done_c != 21) begin n_bad++; $display("FAIL single_done_cycle: got %0d required 21", done_c); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL single_done_width: got %0d required 1", done_cnt); end
      n_cmp++; if (busy_bad) begin n_bad++; $display("FAIL single_busy: got early drop required held"); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (dio_log[2 + 5 * k] !== 32'(k + 1)) begin
            n_bad++; $display("FAIL single_dio%0d: got %h required %h", k, dio_log[2 + 5 * k], k + 1);
         end
      end
      n_cmp++; if (pass !== 1'b1 || error_count !== '0 || first_fail_valid !== 1'b0) begin
         n_bad++; $display("FAIL single_verdict: got pass=%b err=%0d ffv=%b required 1/0/0", pass, error_count, first_fail_valid);
      end
      n_cmp++; if (dut_dio !== 32'd4) begin n_bad++; $display("FAIL single_dio_hold: got %h required 4", dut_dio); end
   endtask

   task automatic test_masked_mismatch;
      key = 0;
      write_vec(2, 32'h0F, 32'hFF, 32'h0F);
      do_run(4, 1, 1, 60, -1, -1, -1);
      n_cmp++; if (pass !== 1'b1 || error_count !== '0) begin
         n_bad++; $display("FAIL mask_low: got pass=%b err=%0d required 1/0", pass, error_count);
      end
      write_vec(2, 32'h0F, 32'hFF, 32'hF0);
      do_run(4, 1, 1, 60, -1, -1, -1);
      n_cmp++; if (pass !== 1'b0 || error_count !== 4'd1 || first_fail_addr !== 4'd2 || first_fail_valid !== 1'b1) begin
         n_bad++; $display("FAIL mask_high: got pass=%b err=%0d ffa=%0d ffv=%b required 0/1/2/1",
                           pass, error_count, first_fail_addr, first_fail_valid);
      end
   endtask

   task automatic test_saturation;
      key = 0;
      write_vec(0, 32'h5, 32'h6, 32'hFF);
      do_run(1, 20, 0, 200, -1, -1, -1);
      n_cmp++; if (done_c != 61) begin n_bad++; $display("FAIL sat_done_cycle: got %0d required 61", done_c); end
      n_cmp++; if (error_count !== 4'hF || first_fail_addr !== '0 || first_fail_valid !== 1'b1 || pass !== 1'b0) begin
         n_bad++; $display("FAIL sat_verdict: got err=%0d ffa=%0d ffv=%b pass=%b required 15/0/1/0",
                           error_count, first_fail_addr, first_fail_valid, pass);
      end
   endtask

   task automatic test_abort;
      key = 0;
      for (int i = 0; i < 3; i++) write_vec(i, 32'h100 + 32'(i), 32'h100 + 32'(i), 32'hFFFF_FFFF);
      // state is SETTLE between edges 2 and 6; abort is sampled on edge 3
      do_run(3, 0, 4, 100, 2, -1, -1);
      n_cmp++; if (done_c != 4) begin n_bad++; $display("FAIL abort_done_cycle: got %0d required 4", done_c); end
      n_cmp++; if (aborted !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL abort_verdict: got abt=%b pass=%b busy=%b required 1/0/0", aborted, pass, busy);
      end
      // abort while idle must leave the verdict alone
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
      n_cmp++; if (aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL abort_idle: got abt=%b busy=%b done=%b required 1/0/0", aborted, busy, done);
      end
      do_run(3, 1, 0, 60, -1, -1, -1);
      n_cmp++; if (done_c != 10 || aborted !== 1'b0 || pass !== 1'b1) begin
         n_bad++; $display("FAIL abort_restart: got done_c=%0d abt=%b pass=%b required 10/0/1", done_c, aborted, pass);
      end
   endtask

   task automatic test_edges;
      key = 0;
      do_run(0, 1, 3, 20, -1, -1, -1);
      n_cmp++; if (done_c != 1 || pass !== 1'b1 || error_count !== '0) begin
         n_bad++; $display("FAIL zero_vectors: got done_c=%0d pass=%b err=%0d required 1/1/0", done_c, pass, error_count);
      end
      for (int i = 0; i < 4; i++) write_vec(i, 32'h40 + 32'(i), 32'h40 + 32'(i), 32'hFFFF_FFFF);
      // start mid-run and a RAM write mid-run must both be ignored
      do_run(4, 1, 2, 60, -1, 5, 7);
      n_cmp++; if (done_c != 21 || done_cnt != 1 || pass !== 1'b1) begin
         n_bad++; $display("FAIL start_busy: got done_c=%0d cnt=%0d pass=%b required 21/1/1", done_c, done_cnt, pass);
      end
      do_run(1, 1, 0, 20, -1, -1, -1);
      n_cmp++; if (dio_log[2] !== m_drive[0]) begin
         n_bad++; $display("FAIL write_busy: got %h required %h", dio_log[2], m_drive[0]);
      end
      // start with abort while idle: start wins; a write in the start cycle is used
      abort         = 1'b1;
      vec_wr_en     = 1'b1;
      vec_wr_addr   = '0;
      vec_wr_drive  = 32'h1234_5678;
      vec_wr_expect = 32'h1234_5678;
      vec_wr_mask   = 32'hFFFF_FFFF;
      m_drive[0] = 32'h1234_5678; m_exp[0] = 32'h1234_5678; m_mask[0] = 32'hFFFF_FFFF;
      do_run(1, 1, 0, 20, -1, -1, -1);
      n_cmp++; if (done_c != 4 || aborted !== 1'b0 || pass !== 1'b1) begin
         n_bad++; $display("FAIL start_abort_idle: got done_c=%0d abt=%b pass=%b required 4/0/1", done_c, aborted, pass);
      end
      n_cmp++; if (dio_log[2] !== 32'h1234_5678) begin
         n_bad++; $display("FAIL write_start_cycle: got %h required 12345678", dio_log[2]);
      end
   endtask

   task automatic test_reset_mid_run;
      int seen;
      num_vectors = 4; pass_count = 0; settle_cycles = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL reset_mid_run: got %0d active cycles required 0", seen); end
   endtask

   task automatic test_wrap;
      int e;
      int ff;
      key = $urandom;
      for (int i = 0; i < DEPTH; i++)
         write_vec(i, $urandom, ($urandom_range(0, 3) == 0) ? $urandom : ($urandom ^ 32'd0), $urandom);
      for (int i = 0; i < DEPTH; i++)
         if (i % 3 != 0) write_vec(i, m_drive[i], m_drive[i] ^ key, m_mask[i]);
      e = model_errs(DEPTH, 2);
      ff = model_ff(DEPTH);
      // 20 requested vectors clamp to the RAM depth
      do_run(20, 2, 0, 200, -1, -1, -1);
      n_cmp++; if (done_c != 1 + 2 * DEPTH * 3) begin
         n_bad++; $display("FAIL wrap_done_cycle: got %0d required %0d", done_c, 1 + 2 * DEPTH * 3);
      end
      for (int j = 0; j < 2 * DEPTH; j++) begin
         n_cmp++;
         if (dio_log[2 + 3 * j] !== m_drive[j % DEPTH]) begin
            n_bad++; $display("FAIL wrap_dio%0d: got %h required %h", j, dio_log[2 + 3 * j], m_drive[j % DEPTH]);
         end
      end
      n_cmp++;
      if (int'(error_count) != e || first_fail_valid !== (ff >= 0) || (ff >= 0 && int'(first_fail_addr) != ff)) begin
         n_bad++; $display("FAIL wrap_verdict: got err=%0d ffv=%b ffa=%0d required err=%0d ff=%0d",
                           error_count, first_fail_valid, first_fail_addr, e, ff);
      end
   endtask

   task automatic test_random;
      int nv, pc, st, p, e, ff, exp_c;
      for (int it = 0; it < 8; it++) begin
         key = $urandom;
         nv = $urandom_range(1, 8);
         pc = $urandom_range(1, 3);
         st = $urandom_range(0, 3);
         for (int i = 0; i < nv; i++) begin
            logic [31:0] d;
            d = $urandom;
            write_vec(i, d, ($urandom_range(0, 2) == 0) ? (d ^ key ^ (32'd1 << $urandom_range(0, 31))) : (d ^ key),
                      ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom);
         end
         p = 3 + st;
         e = model_errs(nv, pc);
         ff = model_ff(nv);
         exp_c = 1 + nv * pc * p;
         do_run(nv, pc, st, exp_c + 10, -1, -1, -1);
         n_cmp++; if (done_c != exp_c || done_cnt != 1 || busy_bad) begin
            n_bad++; $display("FAIL rand%0d_timing: got done_c=%0d cnt=%0d busy_bad=%b required %0d/1/0",
                              it, done_c, done_cnt, busy_bad, exp_c);
         end
         n_cmp++; if (dio_log[2 + p * (nv - 1)] !== m_drive[nv - 1]) begin
            n_bad++; $display("FAIL rand%0d_dio: got %h required %h", it, dio_log[2 + p * (nv - 1)], m_drive[nv - 1]);
         end
         n_cmp++;
         if (int'(error_count) != e || pass !== (e == 0) || first_fail_valid !== (ff >= 0) ||
             int'(first_fail_addr) != ((ff >= 0) ? ff : 0)) begin
            n_bad++; $display("FAIL rand%0d_verdict: got err=%0d pass=%b ffv=%b ffa=%0d required err=%0d ff=%0d",
                              it, error_count, pass, first_fail_valid, first_fail_addr, e, ff);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      key = 0;
      vec_wr_en = 1'b0; vec_wr_addr = '0; vec_wr_drive = '0; vec_wr_expect = '0; vec_wr_mask = '0;
      start = 1'b0; abort = 1'b0;
      num_vectors = '0; pass_count = '0; settle_cycles = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_pass();
      test_masked_mismatch();
      test_saturation();
      test_abort();
      test_edges();
      test_reset_mid_run();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
